// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage. Holds the PC, presents it to the combinational
//   instruction ROM, and latches the returned word into the IF/ID register.
//   Also keeps the fetch and bubble counters used for performance debug.
//
// Ports
//   clk         rising-edge clock
//   clrn        asynchronous active-low reset
//   stall       hold PC and IF/ID (load-use hazard)
//   flush       kill the instruction in IF; load a bubble into IF/ID
//   pcsrc       next-PC select: 00 pc+4, 01 bpc, 10 jpc, 11 same as 00
//   bpc, jpc    branch / jump targets from ID (low two bits ignored)
//   rom_a       ROM address, equal to the PC register
//   rom_inst    ROM data for the current PC (same cycle)
//   id_pc4      IF/ID: PC+4 of the captured instruction
//   id_inst     IF/ID: captured instruction
//   id_valid    IF/ID: 1 = real instruction, 0 = bubble
//   fetch_cnt   instructions delivered to ID, wraps
//   bubble_cnt  bubbles inserted by flush, saturates
// ----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  output logic [31:0] rom_a,
  input  logic [31:0] rom_inst,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic [31:0] fetch_cnt,
  output logic [15:0] bubble_cnt
);

  logic [31:0] pc;
  logic [31:0] pc4;

  // Modulo-2^32 increment: 32'hFFFF_FFFC rolls over to 0.
  assign pc4   = pc + 32'd4;
  assign rom_a = pc;

  // PC register. A redirect from ID takes precedence over a stall so a taken
  // branch is never lost while the hazard unit is holding the pipe.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc <= RESET_PC;
    end else begin
      case (pcsrc)
        2'b01:   pc <= {bpc[31:2], 2'b00};
        2'b10:   pc <= {jpc[31:2], 2'b00};
        default: begin
          if (!stall) pc <= pc4;
        end
      endcase
    end
  end

  // IF/ID register and counters. Flush beats stall so a killed instruction
  // cannot linger in IF/ID behind a hazard hold.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      id_inst    <= NOP_INST;
      id_pc4     <= 32'h0000_0000;
      id_valid   <= 1'b0;
      fetch_cnt  <= 32'h0000_0000;
      bubble_cnt <= 16'h0000;
    end else if (flush) begin
      id_inst  <= NOP_INST;
      id_pc4   <= pc4;
      id_valid <= 1'b0;
      if (bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end else if (!stall) begin
      id_inst   <= rom_inst;
      id_pc4    <= pc4;
      id_valid  <= 1'b1;
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        clrn;
  logic        stall;
  logic        flush;
  logic [1:0]  pcsrc;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] rom_a;
  logic [31:0] rom_inst;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [31:0] fetch_cnt;
  logic [15:0] bubble_cnt;

  logic [31:0] rom [64];

  int errors = 0;
  int checks = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) dut (
    .clk(clk), .clrn(clrn), .stall(stall), .flush(flush), .pcsrc(pcsrc),
    .bpc(bpc), .jpc(jpc), .rom_a(rom_a), .rom_inst(rom_inst),
    .id_pc4(id_pc4), .id_inst(id_inst), .id_valid(id_valid),
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
  );

  assign rom_inst = rom[rom_a[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; flush = 1'b0; pcsrc = 2'b00; bpc = 32'h0; jpc = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + i;
    rom[0] = 32'h0010_0443;
    rom[1] = 32'h0020_1025;

    idle();
    clrn = 1'b0;
    #2;
    // T1: reset values, then free run
    chk("rst_rom_a", rom_a, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_id_pc4", id_pc4, 32'h0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_fetch", fetch_cnt, 32'h0);
    chk("rst_bubble", {16'b0, bubble_cnt}, 32'h0);
    #1 clrn = 1'b1;

    step();
    chk("t1_e1_rom_a", rom_a, 32'h4);
    chk("t1_e1_inst", id_inst, 32'h0010_0443);
    chk("t1_e1_pc4", id_pc4, 32'h4);
    chk("t1_e1_valid", {31'b0, id_valid}, 32'h1);
    step();
    chk("t1_e2_rom_a", rom_a, 32'h8);
    chk("t1_e2_inst", id_inst, 32'h0020_1025);
    chk("t1_e2_pc4", id_pc4, 32'h8);
    chk("t1_e2_fetch", fetch_cnt, 32'h2);

    // T2: stall two edges at pc=8
    stall = 1'b1;
    step();
    step();
    chk("t2_rom_a", rom_a, 32'h8);
    chk("t2_inst", id_inst, 32'h0020_1025);
    chk("t2_pc4", id_pc4, 32'h8);
    chk("t2_fetch", fetch_cnt, 32'h2);
    stall = 1'b0;
    step();
    chk("t2_rel_rom_a", rom_a, 32'hC);
    chk("t2_rel_inst", id_inst, 32'hA000_0002);
    chk("t2_rel_fetch", fetch_cnt, 32'h3);

    // run up to pc=0x20
    for (int i = 0; i < 5; i++) step();
    chk("run_rom_a", rom_a, 32'h20);
    chk("run_inst", id_inst, 32'hA000_0007);
    chk("run_fetch", fetch_cnt, 32'h8);

    // T3: jump to 0 with flush at pc=0x20
    pcsrc = 2'b10; jpc = 32'h0; flush = 1'b1;
    step();
    idle();
    chk("t3_rom_a", rom_a, 32'h0);
    chk("t3_valid", {31'b0, id_valid}, 32'h0);
    chk("t3_inst", id_inst, 32'h0);
    chk("t3_pc4", id_pc4, 32'h24);
    chk("t3_bubble", {16'b0, bubble_cnt}, 32'h1);
    chk("t3_fetch", fetch_cnt, 32'h8);

    // T4: stall + branch to misaligned 0x13 + flush at pc=0
    stall = 1'b1; pcsrc = 2'b01; bpc = 32'h13; flush = 1'b1;
    step();
    idle();
    chk("t4_rom_a", rom_a, 32'h10);
    chk("t4_valid", {31'b0, id_valid}, 32'h0);
    chk("t4_pc4", id_pc4, 32'h4);
    chk("t4_bubble", {16'b0, bubble_cnt}, 32'h2);
    chk("t4_fetch", fetch_cnt, 32'h8);
    step();
    chk("t4_next_rom_a", rom_a, 32'h14);
    chk("t4_next_inst", id_inst, 32'hA000_0004);
    chk("t4_next_valid", {31'b0, id_valid}, 32'h1);

    // pcsrc=11 behaves as pc+4
    pcsrc = 2'b11; bpc = 32'h40; jpc = 32'h80;
    step();
    idle();
    chk("p11_rom_a", rom_a, 32'h18);
    chk("p11_inst", id_inst, 32'hA000_0005);
    chk("p11_fetch", fetch_cnt, 32'hA);

    // Redirect without flush: delay-slot instruction delivered
    pcsrc = 2'b01; bpc = 32'h30;
    step();
    idle();
    chk("ds_rom_a", rom_a, 32'h30);
    chk("ds_inst", id_inst, 32'hA000_0006);
    chk("ds_pc4", id_pc4, 32'h1C);
    chk("ds_fetch", fetch_cnt, 32'hB);

    // T5: jump to top of address space, then wrap
    pcsrc = 2'b10; jpc = 32'hFFFF_FFFF; flush = 1'b1;
    step();
    idle();
    chk("t5_rom_a", rom_a, 32'hFFFF_FFFC);
    chk("t5_bubble", {16'b0, bubble_cnt}, 32'h3);
    step();
    chk("t5_wrap_rom_a", rom_a, 32'h0);
    chk("t5_wrap_pc4", id_pc4, 32'h0);
    chk("t5_wrap_inst", id_inst, 32'hA000_003F);
    chk("t5_wrap_fetch", fetch_cnt, 32'hC);

    // stall + flush without redirect: pc held, bubble loaded
    stall = 1'b1; flush = 1'b1;
    step();
    idle();
    chk("sf_rom_a", rom_a, 32'h0);
    chk("sf_valid", {31'b0, id_valid}, 32'h0);
    chk("sf_pc4", id_pc4, 32'h4);
    chk("sf_bubble", {16'b0, bubble_cnt}, 32'h4);

    // T6: asynchronous reset mid-cycle at pc=0x18
    for (int i = 0; i < 6; i++) step();
    chk("t6_pre_rom_a", rom_a, 32'h18);
    chk("t6_pre_fetch", fetch_cnt, 32'h12);
    #2 clrn = 1'b0;
    #1;
    chk("t6_rom_a", rom_a, 32'h0);
    chk("t6_inst", id_inst, 32'h0);
    chk("t6_pc4", id_pc4, 32'h0);
    chk("t6_valid", {31'b0, id_valid}, 32'h0);
    chk("t6_fetch", fetch_cnt, 32'h0);
    chk("t6_bubble", {16'b0, bubble_cnt}, 32'h0);
    #1 clrn = 1'b1;
    step();
    chk("t6_resume_rom_a", rom_a, 32'h4);
    chk("t6_resume_inst", id_inst, 32'h0010_0443);
    chk("t6_resume_fetch", fetch_cnt, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
